imem_responder: RTL and testbench

- Instruction-memory responder: the memory end of the fetch interface. Accepts word-fetch requests from the fetch stage and returns instruction words after a fixed, parameterised wait-state latency.
- Owns a word-addressed instruction array, writable through a program-load port so benches and boot logic can preload code.
- Supports a flush (taken branch / pc_src) that discards an in-flight fetch.

---
 rtl/imem_responder.sv | 145 ++++++++++++++
 tb/tb_imem_responder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts word fetches, answers after
// WAIT_CYCLES wait states, and exposes a program-load port for preloading.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for a fetch; req_ready follows load_en/flush
// ST_WAIT | wait states; cnt_q counts down to its terminal value 0
// ST_RESP | rsp_valid high, rsp_data/rsp_err held until the handshake
module imem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  input  logic        flush,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        busy
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_data_q, rsp_data_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        load_ok;
  logic [31:0] rd_addr;
  logic        rd_err;
  logic [31:0] rd_result;

  function automatic logic word_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ({2'b00, a[31:2]} < DEPTH_WORDS);
  endfunction

  assign req_ready = (state_q == ST_IDLE) && !load_en && !flush;
  assign accept    = req_valid && req_ready;
  assign load_ok   = load_en && word_ok(load_addr);

  // With zero wait states RESP is entered on the accepting edge, so the
  // lookup must use the incoming address rather than the latched one.
  assign rd_addr   = (state_q == ST_IDLE) ? req_addr : addr_q;
  assign rd_err    = !word_ok(rd_addr);
  assign rd_result = rd_err ? NOP_WORD : mem[rd_addr[AW+1:2]];

  // Next-state and next-output decode for the fetch FSM
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d = req_addr;
          if (WAIT_CYCLES == 0) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = rd_err;
            rsp_data_d  = rd_result;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = rd_err;
          rsp_data_d  = rd_result;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        // A flush coinciding with the handshake still counts as consumed;
        // either way the response is retired.
        if (flush || rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // FSM state and registered response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Program-load write; array is not reset so code survives rst_n.
  // Reads above sample the old word on a same-edge write.
  always_ff @(posedge clk) begin
    if (load_ok) begin
      mem[load_addr[AW+1:2]] <= load_data;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: one instance with two wait states, one with none.
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic        rsp_ready = 1'b0;
  logic        flush = 1'b0;
  logic        load_en = 1'b0;
  logic [31:0] load_addr = 32'd0;
  logic [31:0] load_data = 32'd0;
  logic        use0 = 1'b0;

  logic        req_ready2, rsp_valid2, rsp_err2, busy2;
  logic [31:0] rsp_data2;
  logic        req_ready0, rsp_valid0, rsp_err0, busy0;
  logic [31:0] rsp_data0;

  logic        c_req_ready, c_rsp_valid, c_rsp_err, c_busy;
  logic [31:0] c_rsp_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready2),
    .req_addr(req_addr), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data2), .rsp_err(rsp_err2), .flush(flush), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .busy(busy2));

  imem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready0),
    .req_addr(req_addr), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data0), .rsp_err(rsp_err0), .flush(flush), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .busy(busy0));

  assign c_req_ready = use0 ? req_ready0 : req_ready2;
  assign c_rsp_valid = use0 ? rsp_valid0 : rsp_valid2;
  assign c_rsp_err   = use0 ? rsp_err0   : rsp_err2;
  assign c_busy      = use0 ? busy0      : busy2;
  assign c_rsp_data  = use0 ? rsp_data0  : rsp_data2;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(posedge clk); #2;
    load_en = 1'b0;
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  // Waits for rsp_valid; n counts cycles from the acceptance cycle.
  task automatic wait_rsp(output int n);
    n = 1;
    while (!c_rsp_valid && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
  endtask

  task automatic fetch(input logic [31:0] a, input int lat, input logic [31:0] ed,
                       input logic ee, input string nm);
    int n;
    req_valid = 1'b1; req_addr = a; rsp_ready = 1'b1;
    #1 chk({nm, "_req_ready"}, 32'(c_req_ready), 32'd1);
    @(posedge clk); #2;
    req_valid = 1'b0;
    wait_rsp(n);
    chk({nm, "_latency"}, 32'(n), 32'(lat));
    chk({nm, "_data"}, c_rsp_data, ed);
    chk({nm, "_err"}, 32'(c_rsp_err), 32'(ee));
    @(posedge clk); #2;
    chk({nm, "_idle_after"}, 32'({c_busy, c_rsp_valid}), 32'd0);
  endtask

  task automatic count_rsp(input int cycles, output int seen);
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #2;
      if (c_rsp_valid || c_busy) seen++;
    end
  endtask

  initial begin
    int n;
    int seen;

    vecs[0] = '{addr: 32'h0000_0000, data: 32'h0050_0093, err: 1'b0};
    vecs[1] = '{addr: 32'h0000_0004, data: 32'h00a0_0113, err: 1'b0};
    vecs[2] = '{addr: 32'h0000_0008, data: 32'h0020_81b3, err: 1'b0};
    vecs[3] = '{addr: 32'h0000_0006, data: 32'h0000_0013, err: 1'b1};
    vecs[4] = '{addr: 32'h0000_0400, data: 32'h0000_0013, err: 1'b1};
    vecs[5] = '{addr: 32'h0000_03fc, data: 32'hcafe_f00d, err: 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_rsp_valid", 32'(rsp_valid2), 32'd0);
    chk("rst_busy", 32'(busy2), 32'd0);
    chk("rst_rsp_data", rsp_data2, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err2), 32'd0);
    rst_n = 1'b1;
    #1 chk("rst_req_ready", 32'(req_ready2), 32'd1);

    // Preload, plus two illegal loads that would alias mem[0] if accepted
    load_word(32'h0, 32'h0050_0093);
    load_word(32'h4, 32'h00a0_0113);
    load_word(32'h8, 32'h0020_81b3);
    load_word(32'hc, 32'h0000_0013);
    load_word(32'h3fc, 32'hcafe_f00d);
    load_word(32'h2, 32'hffff_ffff);
    load_word(32'h400, 32'hffff_ffff);

    // Table-driven fetches, two wait states
    for (int i = 0; i < 6; i++)
      fetch(vecs[i].addr, 3, vecs[i].data, vecs[i].err, $sformatf("w2_vec%0d", i));

    // Same first scenario with zero wait states
    rst_pulse();
    use0 = 1'b1;
    for (int i = 0; i < 3; i++)
      fetch(vecs[i].addr, 1, vecs[i].data, vecs[i].err, $sformatf("w0_vec%0d", i));
    use0 = 1'b0;
    rst_pulse();

    // Back-pressure: response held while rsp_ready is low
    req_valid = 1'b1; req_addr = 32'h4; rsp_ready = 1'b0;
    @(posedge clk); #2;
    req_valid = 1'b0;
    wait_rsp(n);
    chk("hold_latency", 32'(n), 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      chk("hold_valid", 32'(c_rsp_valid), 32'd1);
      chk("hold_data", c_rsp_data, 32'h00a0_0113);
      chk("hold_req_ready", 32'(c_req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #2;
    chk("hold_release_idle", 32'({c_busy, c_rsp_valid}), 32'd0);
    chk("hold_release_ready", 32'(c_req_ready), 32'd1);

    // Flush during WAIT drops the fetch
    req_valid = 1'b1; req_addr = 32'h4;
    @(posedge clk); #2;
    req_valid = 1'b0;
    flush = 1'b1;
    #1 chk("flush_wait_busy", 32'(c_busy), 32'd1);
    @(posedge clk); #2;
    flush = 1'b0;
    #1 chk("flush_wait_idle", 32'({c_busy, c_rsp_valid}), 32'd0);
    chk("flush_wait_ready", 32'(c_req_ready), 32'd1);
    count_rsp(6, seen);
    chk("flush_wait_no_rsp", 32'(seen), 32'd0);
    fetch(32'h8, 3, 32'h0020_81b3, 1'b0, "flush_next");

    // Flush during RESP retires the held response
    req_valid = 1'b1; req_addr = 32'h0; rsp_ready = 1'b0;
    @(posedge clk); #2;
    req_valid = 1'b0;
    wait_rsp(n);
    chk("flush_resp_latency", 32'(n), 32'd3);
    flush = 1'b1;
    @(posedge clk); #2;
    flush = 1'b0;
    chk("flush_resp_idle", 32'({c_busy, c_rsp_valid}), 32'd0);

    // Flush in IDLE only blocks acceptance
    req_valid = 1'b1; req_addr = 32'h0; flush = 1'b1;
    #1 chk("flush_idle_ready", 32'(c_req_ready), 32'd0);
    @(posedge clk); #2;
    flush = 1'b0; req_valid = 1'b0;
    chk("flush_idle_not_taken", 32'(c_busy), 32'd0);

    // Load has priority over a same-cycle request
    req_valid = 1'b1; req_addr = 32'h0;
    load_en = 1'b1; load_addr = 32'hc; load_data = 32'h0000_0013;
    #1 chk("loadprio_ready", 32'(c_req_ready), 32'd0);
    @(posedge clk); #2;
    load_en = 1'b0;
    chk("loadprio_not_taken", 32'(c_busy), 32'd0);
    fetch(32'h0, 3, 32'h0050_0093, 1'b0, "loadprio_fetch");

    // Write on the RESP-entry edge returns old data; RESP-time writes don't disturb
    req_valid = 1'b1; req_addr = 32'h4; rsp_ready = 1'b0;
    @(posedge clk); #2;
    req_valid = 1'b0;
    @(posedge clk); #2;
    load_en = 1'b1; load_addr = 32'h4; load_data = 32'hdead_beef;
    @(posedge clk); #2;
    load_en = 1'b0;
    chk("rbw_valid", 32'(c_rsp_valid), 32'd1);
    chk("rbw_data", c_rsp_data, 32'h00a0_0113);
    load_word(32'h4, 32'h1111_1111);
    chk("resp_write_hold1", c_rsp_data, 32'h00a0_0113);
    load_word(32'h4, 32'hdead_beef);
    chk("resp_write_hold2", c_rsp_data, 32'h00a0_0113);
    rsp_ready = 1'b1;
    @(posedge clk); #2;
    chk("rbw_idle", 32'({c_busy, c_rsp_valid}), 32'd0);
    fetch(32'h4, 3, 32'hdead_beef, 1'b0, "rbw_next");

    // Asynchronous reset during WAIT
    req_valid = 1'b1; req_addr = 32'h0;
    @(posedge clk); #2;
    req_valid = 1'b0;
    chk("arst_busy_before", 32'(c_busy), 32'd1);
    #1 rst_n = 1'b0;
    #1 chk("arst_immediate", 32'({c_busy, c_rsp_valid}), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    count_rsp(6, seen);
    chk("arst_no_rsp", 32'(seen), 32'd0);
    fetch(32'h0, 3, 32'h0050_0093, 1'b0, "arst_fetch");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
